conv1_mac_write: RTL

- Downstream of the conv1 input-image address counter. Consumes four parallel pixel lanes, one per image quarter, plus the kernel weight stream.
- Accumulates 25 pixel×weight products per 5×5 window, then applies shift, ReLU and saturation.
- Writes one 8-bit result per lane into the 576-entry (24×24) conv1 output memory, using four parallel write addresses.
- Each lane owns 144 consecutive outputs, so lane base offsets are 0, 144, 288 and 432.

---
 rtl/conv1_pkg.sv | 29 ++
 rtl/conv1_mac_write_if.sv | 31 +++
 rtl/conv1_lane_mac.sv | 72 +++++++
 rtl/conv1_mac_write.sv | 106 ++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// conv1 shared definitions: image/lane geometry, datapath widths, lane base
// addresses into the 576-entry output memory, and the controller state type.
package conv1_pkg;

    localparam int IMG_OUT_W  = 24;
    localparam int OUT_PIXELS = 576;
    localparam int LANES      = 4;
    localparam int KTAPS      = 25;
    localparam int LANE_OUTS  = 144;
    localparam int ACC_W      = 22;
    localparam int SHIFT_DEF  = 8;
    localparam int TAP_W      = 5;
    localparam int CNT_W      = 8;
    localparam int ADDR_W     = 10;

    typedef logic        [7:0]        pixel_t;
    typedef logic signed [7:0]        weight_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic        [ADDR_W-1:0] addr_t;

    // Each lane owns a contiguous quarter of the output image.
    localparam addr_t LANE_BASE [LANES] = '{10'd0, 10'd144, 10'd288, 10'd432};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/conv1_mac_write_if.sv
// Bundle between the conv1 address/pixel front end and the MAC/write stage.
//   start, in_valid, pix0..3, weight : upstream -> MAC
//   tap_idx                          : MAC -> weight ROM address
//   wr_en, wr_addr0..3, wr_data0..3  : MAC -> output memory
//   done                             : image complete
interface conv1_mac_write_if;
    import conv1_pkg::*;

    logic        start;
    logic        in_valid;
    pixel_t      pix0, pix1, pix2, pix3;
    weight_t     weight;
    logic [4:0]  tap_idx;
    logic        wr_en;
    addr_t       wr_addr0, wr_addr1, wr_addr2, wr_addr3;
    pixel_t      wr_data0, wr_data1, wr_data2, wr_data3;
    logic        done;

    modport master (
        output start, in_valid, pix0, pix1, pix2, pix3, weight,
        input  tap_idx, wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3,
               wr_data0, wr_data1, wr_data2, wr_data3, done
    );

    modport slave (
        input  start, in_valid, pix0, pix1, pix2, pix3, weight,
        output tap_idx, wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3,
               wr_data0, wr_data1, wr_data2, wr_data3, done
    );

endinterface

// File: rtl/conv1_lane_mac.sv
// One conv1 lane: accumulates pixel x weight over a 5x5 window and, on the
// last tap, registers shift -> ReLU -> saturate of the final sum.
//   clk, reset     : clock, async active-low reset
//   clear_i        : drop the partial window
//   accumulate_i   : add this beat's product
//   last_i         : this beat closes the window (with accumulate_i)
//   pix_i/weight_i : unsigned pixel, signed weight
//   result_o       : 8-bit result of the most recent window
module conv1_lane_mac
    import conv1_pkg::*;
#(
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    clear_i,
    input  logic    accumulate_i,
    input  logic    last_i,
    input  pixel_t  pix_i,
    input  weight_t weight_i,
    output pixel_t  result_o
);

    localparam acc_t SAT_MAX = acc_t'(255);

    acc_t   pix_ext, wt_ext, prod, sum, shifted;
    acc_t   acc_q, acc_d;
    pixel_t res_q, res_d, sat;

    // Pixel is zero-extended, weight sign-extended; 25 products fit in ACC_W.
    assign pix_ext = {{(ACC_W-8){1'b0}}, pix_i};
    assign wt_ext  = {{(ACC_W-8){weight_i[7]}}, weight_i};
    assign prod    = pix_ext * wt_ext;
    assign sum     = acc_q + prod;
    assign shifted = sum >>> SHIFT;

    always_comb begin
        sat = shifted[7:0];
        if (shifted[ACC_W-1])
            sat = 8'd0;
        else if (shifted > SAT_MAX)
            sat = 8'hFF;
    end

    always_comb begin
        acc_d = acc_q;
        res_d = res_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (accumulate_i) begin
            if (last_i) begin
                acc_d = '0;
                res_d = sat;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign result_o = res_q;

endmodule

// File: rtl/conv1_mac_write.sv
// conv1 MAC and output-memory writer. Four pixel lanes share one weight
// stream; every 25 valid beats each lane writes one byte at its own address.
//   clk, reset : clock, async active-low reset
//   bus        : slave side of conv1_mac_write_if (inputs, tap index,
//                write strobe/addresses/data, done)
//
// state   | meaning
// ST_RUN  | accepting beats, writing one result per window
// ST_DONE | all 144 outputs per lane written; beats ignored until start
module conv1_mac_write
    import conv1_pkg::*;
#(
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    conv1_mac_write_if.slave   bus
);

    state_t             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_en_q, wr_en_d;
    addr_t              addr_q [LANES];
    addr_t              addr_d [LANES];
    logic               accept, last;
    pixel_t             pix [LANES];
    pixel_t             res [LANES];

    assign pix[0] = bus.pix0;
    assign pix[1] = bus.pix1;
    assign pix[2] = bus.pix2;
    assign pix[3] = bus.pix3;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        // start outranks a coincident beat
        accept  = bus.in_valid && (state_q == ST_RUN) && !bus.start;
        last    = accept && (tap_q == TAP_W'(KTAPS-1));
        if (bus.start) begin
            state_d = ST_RUN;
            tap_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            if (last) begin
                tap_d   = '0;
                cnt_d   = cnt_q + 1'b1;
                wr_en_d = 1'b1;
                for (int k = 0; k < LANES; k++)
                    addr_d[k] = LANE_BASE[k] + {2'b00, cnt_q};
                if (cnt_q == CNT_W'(LANE_OUTS-1))
                    state_d = ST_DONE;
            end else begin
                tap_d = tap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            tap_q   <= '0;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            for (int k = 0; k < LANES; k++)
                addr_q[k] <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            for (int k = 0; k < LANES; k++)
                addr_q[k] <= addr_d[k];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        conv1_lane_mac #(.SHIFT(SHIFT)) u_lane (
            .clk          (clk),
            .reset        (reset),
            .clear_i      (bus.start),
            .accumulate_i (accept),
            .last_i       (last),
            .pix_i        (pix[k]),
            .weight_i     (bus.weight),
            .result_o     (res[k])
        );
    end

    assign bus.tap_idx  = tap_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr0 = addr_q[0];
    assign bus.wr_addr1 = addr_q[1];
    assign bus.wr_addr2 = addr_q[2];
    assign bus.wr_addr3 = addr_q[3];
    assign bus.wr_data0 = res[0];
    assign bus.wr_data1 = res[1];
    assign bus.wr_data2 = res[2];
    assign bus.wr_data3 = res[3];
    assign bus.done     = (state_q == ST_DONE);

endmodule
